// File: rtl/my_pkg.sv
// Shared types for the data-memory controller: access sizes, FSM states, byte-lane mask.
package my_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  // Little-endian lane enables; lo must already be aligned for half/word.
  function automatic logic [3:0] lane_mask(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Combinational lane select and sign/zero extension of a loaded word.
module dmem_load_extend
  import my_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            lo,
  input  mem_size_e             size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] ext
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    h = 16'h0000;
    case (lo)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    ext = '0;
    case (size)
      SZ_BYTE: ext = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: ext = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: ext = word;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: response WAIT_CYCLES+1 cycles after accept, held until resp_ready; one access in flight.
// DMEM_ALIGN_CHECK_EN: reject misaligned half/word instead of forcing the low address bits to zero.
module dmem_ctrl
  import my_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int          IDXW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  dmem_state_e           state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] a_addr, a_wdata;
  mem_size_e             a_size;
  logic                  a_we, a_uns;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle;
  logic [DATA_WIDTH-1:0] acc_addr, acc_wdata, offset, lane_wdata, ext, resp_d;
  mem_size_e             acc_size;
  logic                  acc_we, acc_uns, in_range, misalign, bad_align, acc_err, do_access;
  logic [1:0]            lo;
  logic [3:0]            wmask;
  logic [IDXW-1:0]       idx;

  // With no wait states the access happens on the accept edge, straight from the request.
  assign idle      = (state == ST_IDLE);
  assign acc_addr  = idle ? req_addr : a_addr;
  assign acc_wdata = idle ? req_wdata : a_wdata;
  assign acc_size  = idle ? mem_size_e'(req_size) : a_size;
  assign acc_we    = idle ? req_we : a_we;
  assign acc_uns   = idle ? req_unsigned : a_uns;

  assign offset   = acc_addr - BASE_ADDR;
  assign in_range = (acc_addr >= BASE_ADDR) && (offset < SPAN);
  assign idx      = offset[IDXW+1:2];
  assign misalign = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                    ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));

`ifdef DMEM_ALIGN_CHECK_EN
  assign bad_align = misalign;
  assign lo        = acc_addr[1:0];
`else
  assign bad_align = 1'b0;
  assign lo        = (acc_size == SZ_WORD) ? 2'b00 :
                     (acc_size == SZ_HALF) ? {acc_addr[1], 1'b0} : acc_addr[1:0];
`endif

  assign acc_err    = !in_range || (acc_size == SZ_RSVD) || bad_align;
  assign wmask      = (acc_err || !acc_we) ? 4'b0000 : lane_mask(acc_size, lo);
  assign lane_wdata = (acc_size == SZ_BYTE) ? {4{acc_wdata[7:0]}} :
                      (acc_size == SZ_HALF) ? {2{acc_wdata[15:0]}} : acc_wdata;
  assign do_access  = !rst && ((idle && req_valid && (WAIT_CYCLES == 0)) ||
                               ((state == ST_WAIT) && (cnt == 4'd0)));

  always_ff @(posedge clk) begin
    if (do_access) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  dmem_load_extend u_ext (
    .word        (mem[idx]),
    .lo          (lo),
    .size        (acc_size),
    .is_unsigned (acc_uns),
    .ext         (ext)
  );

  assign resp_d = (acc_err || acc_we) ? '0 : ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= 4'd0;
      a_addr     <= '0;
      a_wdata    <= '0;
      a_size     <= SZ_BYTE;
      a_we       <= 1'b0;
      a_uns      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_addr    <= req_addr;
            a_wdata   <= req_wdata;
            a_size    <= mem_size_e'(req_size);
            a_we      <= req_we;
            a_uns     <= req_unsigned;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              resp_valid <= 1'b1;
              resp_rdata <= resp_d;
              resp_err   <= acc_err;
              state      <= ST_RESP;
            end else begin
              cnt   <= 4'(WAIT_CYCLES - 1);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= resp_d;
            resp_err   <= acc_err;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: instance 0 has no wait states, instance 1 has three.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [1:0]  req_size [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.BASE_ADDR(32'h10010000), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_ctrl #(.BASE_ADDR(32'h10010000), .DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input int d, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input int stall,
                      output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("req_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wd; resp_ready[d] = 1'b0;
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("resp_valid", resp_valid[d], 1);
    rd = resp_rdata[d];
    er = resp_err[d];
    for (int i = 0; i < stall; i++) begin
      check("req_ready_busy", req_ready[d], 0);
      check("hold_valid", resp_valid[d], 1);
      check("hold_rdata", resp_rdata[d], rd);
      @(negedge clk);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("valid_drop", resp_valid[d], 0);
    check("ready_back", req_ready[d], 1);
  endtask

  task automatic op(input string tag, input int d, input logic we, input logic [1:0] sz,
                    input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(d, we, sz, uns, addr, wd, 0, rd, er, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, er, exp_er);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_we[d] = 0; req_size[d] = 0; req_unsigned[d] = 0;
      req_addr[d] = 0; req_wdata[d] = 0; resp_ready[d] = 0;
    end
    rst = 1'b1;
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_rdata", resp_rdata[d], 0);
      check("rst_err", resp_err[d], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // 1: word store/load, one-cycle latency
    xact(0, 1, 2'd2, 0, 32'h10010004, 32'hDEADBEEF, 0, rd, er, lat);
    check("sw_rdata_zero", rd, 0);
    check("sw_err", er, 0);
    check("sw_lat", lat, 1);
    xact(0, 0, 2'd2, 0, 32'h10010004, 0, 0, rd, er, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", er, 0);
    check("lw_lat", lat, 1);

    // 2: byte merge and extension
    op("sb", 0, 1, 2'd0, 0, 32'h10010005, 32'h00000080, 0, 0);
    op("lw_merged", 0, 0, 2'd2, 0, 32'h10010004, 0, 32'hDEAD80EF, 0);
    op("lb", 0, 0, 2'd0, 0, 32'h10010005, 0, 32'hFFFFFF80, 0);
    op("lbu", 0, 0, 2'd0, 1, 32'h10010005, 0, 32'h00000080, 0);
    op("lh", 0, 0, 2'd1, 0, 32'h10010006, 0, 32'hFFFFDEAD, 0);
    op("lhu", 0, 0, 2'd1, 1, 32'h10010006, 0, 32'h0000DEAD, 0);

    // 3: range boundaries, no wrap, reserved size
    op("sw_last", 0, 1, 2'd2, 0, 32'h100100FC, 32'hCAFEF00D, 0, 0);
    op("sw_word0", 0, 1, 2'd2, 0, 32'h10010000, 32'h11223344, 0, 0);
    op("lw_below", 0, 0, 2'd2, 0, 32'h1000FFFC, 0, 0, 1);
    op("lw_above", 0, 0, 2'd2, 0, 32'h10010100, 0, 0, 1);
    op("sw_above", 0, 1, 2'd2, 0, 32'h10010100, 32'h99999999, 0, 1);
    op("sw_rsvd", 0, 1, 2'd3, 0, 32'h10010000, 32'h77777777, 0, 1);
    op("lw_last_keep", 0, 0, 2'd2, 0, 32'h100100FC, 0, 32'hCAFEF00D, 0);
    op("lb_top", 0, 0, 2'd0, 0, 32'h100100FF, 0, 32'hFFFFFFCA, 0);
    op("lw_word0_keep", 0, 0, 2'd2, 0, 32'h10010000, 0, 32'h11223344, 0);

    // 5: misaligned halfword store
`ifdef DMEM_ALIGN_CHECK_EN
    op("sh_mis", 0, 1, 2'd1, 0, 32'h10010003, 32'h00005566, 0, 1);
    op("lw_after_sh", 0, 0, 2'd2, 0, 32'h10010000, 0, 32'h11223344, 0);
`else
    op("sh_mis", 0, 1, 2'd1, 0, 32'h10010003, 32'h00005566, 0, 0);
    op("lw_after_sh", 0, 0, 2'd2, 0, 32'h10010000, 0, 32'h55663344, 0);
`endif

    // 4: three wait states with a stalled consumer
    xact(1, 1, 2'd2, 0, 32'h1001000C, 32'h13572468, 0, rd, er, lat);
    check("w3_sw_lat", lat, 4);
    xact(1, 0, 2'd2, 0, 32'h1001000C, 0, 5, rd, er, lat);
    check("w3_lw_lat", lat, 4);
    check("w3_lw_rdata", rd, 32'h13572468);
    check("w3_lw_err", er, 0);

    // 6: reset during the wait of a store drops it
    op("w3_sw_old", 1, 1, 2'd2, 0, 32'h10010008, 32'hDEADBEEF, 0, 0);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h10010008; req_wdata[1] = 32'h0BADF00D;
    @(negedge clk);
    req_valid[1] = 1'b0;
    check("w3_busy_in_wait", req_ready[1], 0);
    rst = 1'b1;
    #1;
    check("midrst_req_ready", req_ready[1], 1);
    check("midrst_resp_valid", resp_valid[1], 0);
    @(negedge clk);
    rst = 1'b0;
    op("w3_lw_old", 1, 0, 2'd2, 0, 32'h10010008, 0, 32'hDEADBEEF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
